lc3_mem_access: RTL

- Memory-access stage directly downstream of the LC-3 execution stage.
- Takes the ALU result Y as an effective address and performs the LD/LDI/ST/STI data-memory transaction through a ready/valid-style memory port.
- For loads, returns the load value and its NPZ condition codes to writeback.
- LDI/STI indirection and wait states are sequenced by an internal FSM with a bounded wait timer.

---
 rtl/lc3_pkg.sv | 23 ++
 rtl/lc3_npz_gen.sv | 20 ++
 rtl/lc3_mem_access.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/lc3_pkg.sv
// Shared LC-3 encodings: memory-op codes, memory-stage FSM states and NPZ layout.
package lc3_pkg;

   localparam logic [1:0] OP_LD  = 2'b00;
   localparam logic [1:0] OP_LDI = 2'b01;
   localparam logic [1:0] OP_ST  = 2'b10;
   localparam logic [1:0] OP_STI = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD_PTR  = 3'd1,
      S_RD_DATA = 3'd2,
      S_WR_DATA = 3'd3,
      S_FIN     = 3'd4,
      S_ABORT   = 3'd5
   } mem_state_e;

   localparam int NPZ_N = 2;
   localparam int NPZ_P = 1;
   localparam int NPZ_Z = 0;
   localparam logic [2:0] NPZ_RESET = 3'b001;

endpackage

// File: rtl/lc3_npz_gen.sv
// Condition-code generator: one-hot N/P/Z flags for a 16-bit two's-complement value.
module lc3_npz_gen
   import lc3_pkg::*;
(
   input  logic [15:0] value_i,
   output logic [2:0]  npz_o
);

   always_comb begin
      npz_o = '0;
      if (value_i == 16'h0000) begin
         npz_o[NPZ_Z] = 1'b1;
      end else if (value_i[15]) begin
         npz_o[NPZ_N] = 1'b1;
      end else begin
         npz_o[NPZ_P] = 1'b1;
      end
   end

endmodule

// File: rtl/lc3_mem_access.sv
// LC-3 memory-access stage: LD/LDI/ST/STI over a ready/valid memory port with
// a bounded wait timer per request.
//
// state     | meaning
// ----------+----------------------------------------------------
// S_IDLE    | waiting for START
// S_RD_PTR  | reading the indirection pointer (LDI/STI)
// S_RD_DATA | reading the load value
// S_WR_DATA | writing store data
// S_FIN     | DONE pulse (plus WB_EN for loads)
// S_ABORT   | ERR pulse after a request timed out
module lc3_mem_access
   import lc3_pkg::*;
#(
   parameter int TIMEOUT = 15,
   parameter int TW      = 8
) (
   input  logic        clk_i,
   input  logic        reset_n_i,
   input  logic        start_i,
   input  logic [1:0]  op_i,
   input  logic [15:0] addr_i,
   input  logic [15:0] st_data_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic        wb_en_o,
   output logic [15:0] load_data_o,
   output logic [2:0]  npz_o,
   output logic [15:0] mem_addr_o,
   output logic [15:0] mem_wdata_o,
   output logic        mem_re_o,
   output logic        mem_we_o,
   input  logic [15:0] mem_rdata_i,
   input  logic        mem_ready_i
);

   mem_state_e    state_q;
   logic [1:0]    op_q;
   logic [TW-1:0] timer_q;
   logic          busy_q, done_q, err_q, wb_en_q, mem_re_q, mem_we_q;
   logic [15:0]   mem_addr_q, mem_wdata_q, load_data_q;

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q     <= S_IDLE;
         op_q        <= OP_LD;
         timer_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         wb_en_q     <= 1'b0;
         mem_re_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         load_data_q <= '0;
      end else begin
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         wb_en_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  op_q        <= op_i;
                  mem_wdata_q <= st_data_i;
                  mem_addr_q  <= addr_i;
                  timer_q     <= '0;
                  busy_q      <= 1'b1;
                  if (op_i == OP_LD) begin
                     state_q  <= S_RD_DATA;
                     mem_re_q <= 1'b1;
                  end else if (op_i == OP_ST) begin
                     state_q  <= S_WR_DATA;
                     mem_we_q <= 1'b1;
                  end else begin
                     state_q  <= S_RD_PTR;
                     mem_re_q <= 1'b1;
                  end
               end
            end
            S_RD_PTR, S_RD_DATA, S_WR_DATA: begin
               if (mem_ready_i) begin
                  // Ready on the last permitted cycle still completes the request.
                  timer_q <= '0;
                  if (state_q == S_RD_PTR) begin
                     mem_addr_q <= mem_rdata_i;
                     if (op_q == OP_STI) begin
                        state_q  <= S_WR_DATA;
                        mem_re_q <= 1'b0;
                        mem_we_q <= 1'b1;
                     end else begin
                        state_q <= S_RD_DATA;
                     end
                  end else begin
                     if (state_q == S_RD_DATA) begin
                        load_data_q <= mem_rdata_i;
                     end
                     state_q  <= S_FIN;
                     mem_re_q <= 1'b0;
                     mem_we_q <= 1'b0;
                     done_q   <= 1'b1;
                     wb_en_q  <= (op_q == OP_LD) || (op_q == OP_LDI);
                  end
               end else if (timer_q == TW'(TIMEOUT)) begin
                  state_q  <= S_ABORT;
                  mem_re_q <= 1'b0;
                  mem_we_q <= 1'b0;
                  err_q    <= 1'b1;
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            S_FIN, S_ABORT: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   lc3_npz_gen u_npz_gen (
      .value_i (load_data_q),
      .npz_o   (npz_o)
   );

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign wb_en_o     = wb_en_q;
   assign load_data_o = load_data_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign mem_re_o    = mem_re_q;
   assign mem_we_o    = mem_we_q;

endmodule
